// File: rtl/lexer_pkg.sv
// Shared definitions for the word lexer: token kinds, FSM states, ASCII constants.
package lexer_pkg;

  localparam logic [1:0] TOK_NONE  = 2'b00;
  localparam logic [1:0] TOK_BEGIN = 2'b01;
  localparam logic [1:0] TOK_END   = 2'b10;
  localparam logic [1:0] TOK_OTHER = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_B1,
    ST_B2,
    ST_B3,
    ST_B4,
    ST_B5,
    ST_E1,
    ST_E2,
    ST_E3,
    ST_OTH
  } state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_UA    = 8'h41;
  localparam logic [7:0] CH_UZ    = 8'h5A;
  localparam logic [7:0] CASE_OFS = 8'h20;

  // Kind a word would get if it ended while the FSM sits in state s.
  function automatic logic [1:0] state_kind(input state_t s);
    case (s)
      ST_IDLE: state_kind = TOK_NONE;
      ST_B5:   state_kind = TOK_BEGIN;
      ST_E3:   state_kind = TOK_END;
      default: state_kind = TOK_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/ascii_fold.sv
// Combinational character front end: uppercase-to-lowercase fold and class decode.
module ascii_fold
  import lexer_pkg::*;
(
  input  logic [7:0] ch,
  output logic [7:0] folded,
  output logic       is_delim,
  output logic       is_idle
);

  // Fold 'A'-'Z' down to lowercase and flag the delimiter and idle bytes.
  always_comb begin
    folded   = ch;
    if (ch >= CH_UA && ch <= CH_UZ) folded = ch + CASE_OFS;
    is_delim = (ch == CH_SPACE);
    is_idle  = (ch == CH_NUL);
  end

endmodule

// File: rtl/word_lexer.sv
// Segments the ASCII stream into space-delimited words and classifies each one
// as BEGIN, END or OTHER, emitting one registered token per completed word.
module word_lexer
  import lexer_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  output logic             tok_valid,
  output logic [1:0]       tok_kind,
  output logic [LEN_W-1:0] tok_len,
  output logic [1:0]       pend_kind,
  output logic             in_word
);

  logic [7:0]       ch_p0;
  logic             delim_p0;
  logic             idle_p0;

  state_t           state_p1;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_p1;
  logic [LEN_W-1:0] len_nxt;
  logic             emit;

  ascii_fold u_fold (
    .ch       (in),
    .folded   (ch_p0),
    .is_delim (delim_p0),
    .is_idle  (idle_p0)
  );

  // Length counter sticks at its maximum instead of wrapping.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    sat_inc = (&v) ? v : v + LEN_W'(1);
  endfunction

  // Keyword matcher: walks "begin" / "end" prefixes, anything else falls into OTH.
  function automatic state_t advance(input state_t s, input logic [7:0] c);
    advance = ST_OTH;
    case (s)
      ST_IDLE: begin
        if (c == "b")      advance = ST_B1;
        else if (c == "e") advance = ST_E1;
      end
      ST_B1:   if (c == "e") advance = ST_B2;
      ST_B2:   if (c == "g") advance = ST_B3;
      ST_B3:   if (c == "i") advance = ST_B4;
      ST_B4:   if (c == "n") advance = ST_B5;
      ST_E1:   if (c == "n") advance = ST_E2;
      ST_E2:   if (c == "d") advance = ST_E3;
      default: advance = ST_OTH;
    endcase
  endfunction

  // Next state and counter; idle bytes freeze everything, a delimiter closes a word.
  always_comb begin
    state_nxt = state_p1;
    len_nxt   = len_p1;
    emit      = 1'b0;
    if (!idle_p0) begin
      if (delim_p0) begin
        if (state_p1 != ST_IDLE) begin
          emit      = 1'b1;
          state_nxt = ST_IDLE;
          len_nxt   = '0;
        end
      end else begin
        state_nxt = advance(state_p1, ch_p0);
        len_nxt   = sat_inc(len_p1);
      end
    end
  end

  // ---- stage p1: FSM state, length counter and registered outputs ----
  // State/counter update and one-cycle token pulse; reset discards any open word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1  <= ST_IDLE;
      len_p1    <= '0;
      tok_valid <= 1'b0;
      tok_kind  <= TOK_NONE;
      tok_len   <= '0;
      pend_kind <= TOK_NONE;
      in_word   <= 1'b0;
    end else begin
      state_p1  <= state_nxt;
      len_p1    <= len_nxt;
      tok_valid <= emit;
      tok_kind  <= emit ? state_kind(state_p1) : TOK_NONE;
      tok_len   <= emit ? len_p1 : '0;
      pend_kind <= state_kind(state_nxt);
      in_word   <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_word_lexer.sv
// Self-checking bench for word_lexer: directed scenarios plus a randomized
// stream, all checked cycle by cycle against a word-buffer reference model.
module tb_word_lexer;

  localparam int LEN_W   = 6;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       in = 8'h00;
  logic             tok_valid;
  logic [1:0]       tok_kind;
  logic [LEN_W-1:0] tok_len;
  logic [1:0]       pend_kind;
  logic             in_word;

  int checks = 0;
  int failures = 0;

  // Reference model: the folded characters of the word currently open.
  byte unsigned     wq[$];
  logic [11:0]      exp_vec;

  // Tokens observed on the DUT outputs during the current scenario.
  logic [1:0]       obs_kind[$];
  int               obs_len[$];

  word_lexer #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .tok_valid (tok_valid),
    .tok_kind  (tok_kind),
    .tok_len   (tok_len),
    .pend_kind (pend_kind),
    .in_word   (in_word)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] dut_vec();
    return {tok_valid, tok_kind, tok_len, pend_kind, in_word};
  endfunction

  function automatic logic [1:0] classify();
    if (wq.size() == 0) return 2'b00;
    if (wq.size() == 5 && wq[0] == "b" && wq[1] == "e" && wq[2] == "g" &&
        wq[3] == "i" && wq[4] == "n") return 2'b01;
    if (wq.size() == 3 && wq[0] == "e" && wq[1] == "n" && wq[2] == "d") return 2'b10;
    return 2'b11;
  endfunction

  // Drive one byte, let the DUT sample it, then advance the model.
  task automatic drive_char(input byte unsigned c);
    logic       tv;
    logic [1:0] tk;
    int         tl;
    @(negedge clk);
    in = c;
    @(posedge clk);
    #1;
    tv = 1'b0;
    tk = 2'b00;
    tl = 0;
    if (c == 8'h20) begin
      if (wq.size() > 0) begin
        tv = 1'b1;
        tk = classify();
        tl = (wq.size() > LEN_MAX) ? LEN_MAX : wq.size();
        wq.delete();
      end
    end else if (c != 8'h00) begin
      wq.push_back((c >= "A" && c <= "Z") ? c + 8'h20 : c);
    end
    exp_vec = {tv, tk, LEN_W'(tl), classify(), (wq.size() > 0)};
    if (tok_valid === 1'b1) begin
      obs_kind.push_back(tok_kind);
      obs_len.push_back(int'(tok_len));
    end
  endtask

  task automatic do_reset(input byte unsigned c);
    @(negedge clk);
    reset = 1'b1;
    in = c;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wq.delete();
    obs_kind.delete();
    obs_len.delete();
  endtask

  task automatic test_reset();
    do_reset(8'h62);
    checks++;
    if (dut_vec() !== 12'h000) begin
      failures++;
      $display("FAIL reset_values got=%h want=000", dut_vec());
    end
  endtask

  task automatic test_begin();
    string s = "begin ";
    obs_kind.delete(); obs_len.delete();
    for (int i = 0; i < s.len(); i++) begin
      drive_char(s[i]);
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL begin_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
      if (i == 4) begin
        checks++;
        if (pend_kind !== 2'b01) begin
          failures++;
          $display("FAIL begin_pend got=%0d want=1", pend_kind);
        end
      end
    end
    checks++;
    if (obs_kind.size() != 1 || obs_kind[0] !== 2'b01 || obs_len[0] != 5 || pend_kind !== 2'b00) begin
      failures++;
      $display("FAIL begin_token count=%0d pend=%0d want one BEGIN len 5, pend 0", obs_kind.size(), pend_kind);
    end
  endtask

  task automatic test_mixed_case();
    string s = "EnD BeGin ";
    obs_kind.delete(); obs_len.delete();
    for (int i = 0; i < s.len(); i++) begin
      drive_char(s[i]);
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL case_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
    end
    checks++;
    if (obs_kind.size() != 2 || obs_kind[0] !== 2'b10 || obs_len[0] != 3 ||
        obs_kind[1] !== 2'b01 || obs_len[1] != 5) begin
      failures++;
      $display("FAIL case_tokens count=%0d want END/3 then BEGIN/5", obs_kind.size());
    end
  endtask

  task automatic test_others();
    string s = "endbegin xyzz beg en ";
    int exp_l[4] = '{8, 4, 3, 2};
    obs_kind.delete(); obs_len.delete();
    for (int i = 0; i < s.len(); i++) begin
      drive_char(s[i]);
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL other_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
    end
    checks++;
    if (obs_kind.size() != 4) begin
      failures++;
      $display("FAIL other_count got=%0d want=4", obs_kind.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_kind[k] !== 2'b11 || obs_len[k] != exp_l[k]) begin
          failures++;
          $display("FAIL other_tok%0d got=%0d/%0d want=3/%0d", k, obs_kind[k], obs_len[k], exp_l[k]);
        end
      end
    end
  endtask

  task automatic test_spaces();
    string s = "   end  ";
    obs_kind.delete(); obs_len.delete();
    for (int i = 0; i < s.len(); i++) begin
      drive_char(s[i]);
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL space_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
    end
    checks++;
    if (obs_kind.size() != 1 || obs_kind[0] !== 2'b10 || obs_len[0] != 3) begin
      failures++;
      $display("FAIL space_tokens count=%0d want one END len 3", obs_kind.size());
    end
  endtask

  task automatic test_idle();
    byte unsigned seq[9] = '{"b", "e", 8'h00, 8'h00, "g", "i", "n", " ", 8'h00};
    obs_kind.delete(); obs_len.delete();
    for (int i = 0; i < 9; i++) begin
      drive_char(seq[i]);
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL idle_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
    end
    checks++;
    if (obs_kind.size() != 1 || obs_kind[0] !== 2'b01 || obs_len[0] != 5) begin
      failures++;
      $display("FAIL idle_tokens count=%0d want one BEGIN len 5", obs_kind.size());
    end
  endtask

  task automatic test_saturation();
    obs_kind.delete(); obs_len.delete();
    for (int i = 0; i < 71; i++) begin
      drive_char((i == 70) ? 8'h20 : "a");
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL sat_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
    end
    checks++;
    if (obs_kind.size() != 1 || obs_kind[0] !== 2'b11 || obs_len[0] != 63) begin
      failures++;
      $display("FAIL sat_token count=%0d want one OTHER len 63", obs_kind.size());
    end
  endtask

  task automatic test_reset_mid_word();
    string s1 = "begi";
    string s2 = " end ";
    for (int i = 0; i < s1.len(); i++) drive_char(s1[i]);
    // A space arriving together with reset must not close the word.
    do_reset(8'h20);
    checks++;
    if (dut_vec() !== 12'h000) begin
      failures++;
      $display("FAIL midreset_clear got=%h want=000", dut_vec());
    end
    for (int i = 0; i < s2.len(); i++) begin
      drive_char(s2[i]);
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL midreset_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
    end
    checks++;
    if (obs_kind.size() != 1 || obs_kind[0] !== 2'b10 || obs_len[0] != 3) begin
      failures++;
      $display("FAIL midreset_tokens count=%0d want one END len 3", obs_kind.size());
    end
  endtask

  task automatic test_random();
    string        pool = "bBeEgGiInNdD";
    byte unsigned c;
    int           r;
    int           ntok = 0;
    obs_kind.delete(); obs_len.delete();
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 1)      c = 8'h20;
      else if (r == 2) c = 8'h00;
      else if (r <= 7) c = pool[$urandom_range(0, pool.len() - 1)];
      else if (r == 8) c = 8'(8'h61 + $urandom_range(0, 25));
      else             c = 8'($urandom_range(1, 255));
      if (c == 8'h20 && wq.size() > 0) ntok++;
      drive_char(c);
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL rand_cycle%0d in=%h got=%h want=%h", i, c, dut_vec(), exp_vec);
      end
    end
    checks++;
    if (obs_kind.size() != ntok) begin
      failures++;
      $display("FAIL rand_token_count got=%0d want=%0d", obs_kind.size(), ntok);
    end
  endtask

  initial begin
    test_reset();
    test_begin();
    test_mixed_case();
    test_others();
    test_spaces();
    test_idle();
    test_saturation();
    test_reset_mid_word();
    test_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_lexer.md
Name: word_lexer

Overview:
- Upstream front end of the begin/end block checker.
- Consumes the raw ASCII character stream, one byte per clock, and segments it into space-delimited words.
- Classifies each word case-insensitively as BEGIN, END or OTHER.
- Emits one registered token per completed word, and continuously exposes the classification of the word currently in progress, so the checker sees tokens instead of raw characters.

Parameters:
- LEN_W, 6, width of the word-length counter; the length saturates at 2^LEN_W-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is sampled high
- in  input  8  ASCII character sampled every rising edge
- tok_valid  output  1  one-cycle pulse: a word ended on the previous edge
- tok_kind  output  2  kind of the ended word: 00 NONE, 01 BEGIN, 10 END, 11 OTHER; 00 whenever tok_valid=0
- tok_len  output  LEN_W  length of the ended word, saturating; 0 whenever tok_valid=0
- pend_kind  output  2  classification of the word in progress if it ended now: 00 when between words, else 01/10/11
- in_word  output  1  high while inside a word (at least one non-space char since the last delimiter)

Behaviour:
- Character classes:
  - 0x20 is the delimiter.
  - 0x00 is idle: no state change, and tok_valid is forced 0 on the following cycle.
  - 'A'-'Z' fold to 'a'-'z'.
  - Every other byte is a word character.
- FSM states: IDLE, B1 "b", B2 "be", B3 "beg", B4 "begi", B5 "begin", E1 "e", E2 "en", E3 "end", OTH.
- Transitions on a word character:
  - IDLE: b->B1, e->E1, else OTH.
  - B1: e->B2. B2: g->B3. B3: i->B4. B4: n->B5.
  - E1: n->E2. E2: d->E3.
  - Any mismatch, and any char in B5, E3 or OTH, goes to OTH. OTH is absorbing until a delimiter.
- Transitions on a delimiter:
  - IDLE stays IDLE with no token.
  - Any other state goes to IDLE and emits a token: B5 gives BEGIN, E3 gives END, all others give OTHER.
  - Prefixes such as "beg" and "en" give OTHER.
- Length counter:
  - Increments on each word character and saturates at 2^LEN_W-1.
  - Resets to 0 when a token is emitted.
- Token timing:
  - The delimiter is sampled at edge k. tok_valid, tok_kind and tok_len are high/valid from edge k to edge k+1 (registered, latency 1).
  - They return to 0/00/0 at edge k+1 unless another token is emitted, which cannot happen, because consecutive delimiters emit nothing.
- pend_kind and in_word are registered and reflect state after the latest sampled character. Mapping from state: B5->01, E3->10, IDLE->00, all else 11.
- Reset values: tok_valid=0, tok_kind=00, tok_len=0, pend_kind=00, in_word=0, state IDLE, counter 0.
- Reset mid-word discards the word with no token emitted. Reset wins over any simultaneous input.
- Leading spaces and multiple spaces produce no tokens.
- A word with no trailing delimiter is never emitted as a token; it is visible only through pend_kind.

Decomposition:
- Shared package lexer_pkg holds:
  - token kind constants TOK_NONE/TOK_BEGIN/TOK_END/TOK_OTHER;
  - state encodings;
  - the ASCII constants (space, NUL, 'A', 'Z', case offset 0x20).
- One natural sub-module, ascii_fold: combinational lowercase fold plus class decode (is_delim, is_idle). The FSM, counter and output registers stay in word_lexer.

Test Plan:
- Reset held 1 cycle, then "begin " -> single tok_valid pulse the cycle after the space, tok_kind=01, tok_len=5; pend_kind=01 before the space, 00 after.
- "EnD BeGin " -> tokens END (len 3) then BEGIN (len 5); tok_valid low on every non-delimiter cycle.
- "endbegin xyzz beg en " -> four tokens, all OTHER, lengths 8, 4, 3, 2.
- "   end  " -> exactly one token END (len 3); no token for any other space.
- A 70-char word of 'a' then space, LEN_W=6 -> tok_kind=11, tok_len=63.
- "begi" then reset high 1 cycle then " end " -> no token from the discarded word, in_word=0 after reset, then one END token.
